nf_ecc_corrector: RTL and testbench
===================================

# nf_ecc_corrector

Post-read ECC check-and-repair stage for one 512-byte NAND sector held in the page dual-port RAM. After the ECC generator produces the 24-bit Hamming code for a sector read from flash, this block compares it with the code stored in the spare area and classifies the result. On a single-bit data error it read-modify-writes the offending RAM word through RAM port A, before the page is released to the EBI side. It sits between the ECC generator and the NAND controller's completion path, and shares port A through the top-level address/write mux.

## Interface
Parameters:
- RAM_AW, 9: RAM word-address width (512 x 32-bit page buffer).
- RAM_LAT, 1: RAM port-A read latency in cycles (1..3).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- sector  in  2  sector index within the page; sector base word = sector*128.
- ecc_calc  in  24  code computed from the data read back.
- ecc_stored  in  24  code read from the spare area.
- ram_req  out  1  port-A ownership request; top mux selects this block while it is high.
- ram_addr  out  RAM_AW  port-A word address.
- ram_we  out  1  port-A write enable.
- ram_wdata  out  32  port-A write data.
- ram_rdata  in  32  port-A read data.
- busy  out  1  high from the cycle after an accepted start until DONE inclusive.
- done  out  1  one-cycle completion pulse.
- status  out  2  result code, valid from done until the next accepted start:
  - 00 clean
  - 01 corrected
  - 10 ECC-field error (data intact)
  - 11 uncorrectable
- err_loc  out  12  {byte_addr[8:0], bit[2:0]} of the corrected bit; 0 unless status=01.

## Operation
- Syndrome s = ecc_calc ^ ecc_stored. Pair k (k = 0..11) = {s[2k+1], s[2k]}. Location bit L[k] = s[2k+1].
- Classification:
  - s == 0 → clean.
  - Every pair is 01 or 10 (popcount 12) → correctable; err_loc = L.
  - popcount(s) == 1 → ECC-field error.
  - Anything else → uncorrectable.
- Correction target:
  - Byte address b = L[11:3], bit index = L[2:0].
  - Word address = {sector, b[8:2]}; byte lane = b[1:0], lane 0 = bits[7:0].
  - Flip mask = 1 << (b[1:0]*8 + L[2:0]).
- FSM states and transitions:
  - IDLE: on start → CHECK; start and ecc inputs are latched on that edge.
  - CHECK: computes the class; correctable → RD, otherwise → DONE.
  - RD: drives ram_addr; → WAIT.
  - WAIT: lasts RAM_LAT cycles; ram_rdata is captured on the last WAIT edge; → WR.
  - WR: ram_we = 1, ram_wdata = captured ^ mask; → DONE.
  - DONE: done = 1, status updated; → IDLE.
- ram_req is high in RD, WAIT and WR. ram_addr is held constant through those states and is 0 otherwise. ram_we is high only in WR.
- A start received while not in IDLE is ignored, with no queueing. Inputs may change once start has been accepted.

## Timing
- Cycle 0 = the edge on which start is accepted.
- No RAM access (clean / ECC-field error / uncorrectable): CHECK in cycle 1, done in cycle 2.
- Correction: RD in cycle 2, WAIT in cycles 3..2+RAM_LAT, WR in cycle 3+RAM_LAT, done in cycle 4+RAM_LAT. With RAM_LAT=1, done is in cycle 5.
- Exactly one RAM write per correction. No write at all in the other three cases.
- Reset values: state IDLE; busy, done, ram_req, ram_we all 0; ram_addr 0; ram_wdata 0; status 00; err_loc 0.
- Reset asserted mid-operation (including during WR): all outputs return to reset values on the next edge. No partial write follows, and no done is issued.
- start coincident with rst: rst wins.

## Structure
- Shared package nf_ecc_pkg, containing:
  - status codes ST_CLEAN, ST_CORR, ST_ECCERR, ST_UNCORR;
  - the FSM state encoding;
  - ECC_W = 24 and SECTOR_BYTES = 512.
- One sub-module: nf_ecc_syndrome, purely combinational. It takes the two 24-bit codes and produces the class (2 bits) and loc (12 bits). The FSM registers its outputs in CHECK.

## Test plan
- Clean: ecc_calc = ecc_stored = 0x3C5A96 → status 00 in cycle 2; ram_req and ram_we never asserted.
- Single-bit correction: sector = 2, ecc_calc = 0x000000, ecc_stored = 0xA6599A, RAM[0x169] = 0x12345E78 → err_loc 0xD2B, ram_addr 0x169, one write of 0x12345678 in cycle 4, status 01 with done in cycle 5.
- ECC-field error: ecc_stored = ecc_calc ^ 0x000400 → status 10, no RAM traffic, done in cycle 2.
- Uncorrectable: syndrome 0x000003 (pair 0 = 11) and syndrome 0x0000F0 → status 11, no write.
- start pulsed again during WAIT with different inputs → ignored; first result unchanged; exactly one done.
- rst asserted in the WR cycle → ram_we low on the next edge, RAM word unchanged, no done; a new start afterwards completes normally. Repeat the correction case with RAM_LAT = 3: done in cycle 7.

Source files
------------

// File: rtl/nf_ecc_pkg.sv
// Shared types and constants for the NAND sector ECC check-and-repair stage.
package nf_ecc_pkg;
  localparam int ECC_W        = 24;
  localparam int SECTOR_BYTES = 512;
  localparam int NPAIR        = ECC_W / 2;
  localparam int LOC_W        = NPAIR;

  typedef enum logic [1:0] {
    ST_CLEAN  = 2'b00,
    ST_CORR   = 2'b01,
    ST_ECCERR = 2'b10,
    ST_UNCORR = 2'b11
  } ecc_status_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_RD    = 3'd2,
    S_WAIT  = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } ecc_state_e;
endpackage

// File: rtl/nf_ecc_syndrome.sv
// Combinational syndrome classifier: clean / single-bit data error / ECC-field error / uncorrectable.
module nf_ecc_syndrome
  import nf_ecc_pkg::*;
(
  input  logic [ECC_W-1:0] i_calc,
  input  logic [ECC_W-1:0] i_stored,
  output ecc_status_e      o_class,
  output logic [LOC_W-1:0] o_loc
);
  logic [ECC_W-1:0] w_syn;
  logic [NPAIR-1:0] w_pair_ok;
  logic [LOC_W-1:0] w_loc;

  assign w_syn = i_calc ^ i_stored;

  // A data-bit error flips exactly one bit of every even/odd pair; the odd bit carries the address.
  for (genvar k = 0; k < NPAIR; k++) begin : g_pair
    assign w_pair_ok[k] = w_syn[2*k] ^ w_syn[2*k+1];
    assign w_loc[k]     = w_syn[2*k+1];
  end

  always_comb begin
    o_class = ST_UNCORR;
    if (w_syn == '0)          o_class = ST_CLEAN;
    else if (&w_pair_ok)      o_class = ST_CORR;
    else if ($onehot(w_syn))  o_class = ST_ECCERR;
  end

  assign o_loc = (o_class == ST_CORR) ? w_loc : '0;
endmodule

// File: rtl/nf_ecc_corrector.sv
// Post-read ECC check; repairs a single flipped data bit in the page RAM via a port-A read-modify-write.
module nf_ecc_corrector
  import nf_ecc_pkg::*;
#(
  parameter int RAM_AW  = 9,
  parameter int RAM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_sector,
  input  logic [ECC_W-1:0]  i_ecc_calc,
  input  logic [ECC_W-1:0]  i_ecc_stored,
  output logic              o_ram_req,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_status,
  output logic [LOC_W-1:0]  o_err_loc
);
  ecc_state_e        r_state, w_next;
  logic [1:0]        r_sector;
  logic [ECC_W-1:0]  r_calc, r_stored;
  logic [LOC_W-1:0]  r_loc;
  logic [1:0]        r_wait_cnt;
  logic [31:0]       r_rdata;
  logic [1:0]        r_status;
  logic [LOC_W-1:0]  r_err_loc;

  ecc_status_e       w_class;
  logic [LOC_W-1:0]  w_loc;
  logic              w_wait_last;
  logic              w_access;
  logic [RAM_AW-1:0] w_addr;
  logic [31:0]       w_mask;

  nf_ecc_syndrome u_syn (
    .i_calc   (r_calc),
    .i_stored (r_stored),
    .o_class  (w_class),
    .o_loc    (w_loc)
  );

  // loc = {byte[8:0], bit[2:0]}: word = {sector, byte[8:2]}, bit-in-word = {byte[1:0], bit} = loc[4:0].
  assign w_addr      = RAM_AW'({r_sector, r_loc[11:5]});
  assign w_mask      = 32'd1 << r_loc[4:0];
  assign w_wait_last = (r_wait_cnt == 2'(RAM_LAT - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_CHECK;
      S_CHECK: w_next = (w_class == ST_CORR) ? S_RD : S_DONE;
      S_RD:    w_next = S_WAIT;
      S_WAIT:  if (w_wait_last) w_next = S_WR;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_sector   <= '0;
      r_calc     <= '0;
      r_stored   <= '0;
      r_loc      <= '0;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
      r_status   <= ST_CLEAN;
      r_err_loc  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_start) begin
        r_sector <= i_sector;
        r_calc   <= i_ecc_calc;
        r_stored <= i_ecc_stored;
      end
      if (r_state == S_CHECK) begin
        r_loc <= w_loc;
        if (w_class != ST_CORR) begin
          r_status  <= w_class;
          r_err_loc <= '0;
        end
      end
      if (r_state == S_RD)        r_wait_cnt <= '0;
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 2'd1;
      if (r_state == S_WAIT && w_wait_last) r_rdata <= i_ram_rdata;
      if (r_state == S_WR) begin
        r_status  <= ST_CORR;
        r_err_loc <= r_loc;
      end
    end
  end

  assign w_access    = (r_state == S_RD) || (r_state == S_WAIT) || (r_state == S_WR);
  assign o_ram_req   = w_access;
  assign o_ram_addr  = w_access ? w_addr : '0;
  // Reset in the WR cycle must stop the RAM from committing the write on that same edge.
  assign o_ram_we    = (r_state == S_WR) && !i_rst;
  assign o_ram_wdata = (r_state == S_WR) ? (r_rdata ^ w_mask) : '0;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_status    = r_status;
  assign o_err_loc   = r_err_loc;
endmodule

// File: tb/tb_nf_ecc_corrector.sv
// Bench for nf_ecc_corrector: vector table, randomized model check, and restart/reset/latency sequences.
module tb_nf_ecc_corrector;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]        st;
  logic [1:0][1:0]   sec;
  logic [1:0][23:0]  calc, stor;
  wire  [1:0]        req, we, busy, done;
  wire  [1:0][8:0]   addr;
  wire  [1:0][31:0]  wdata;
  wire  [1:0][1:0]   status;
  wire  [1:0][11:0]  eloc;
  logic [31:0]       rd0, rd1, p1, p2;

  nf_ecc_corrector #(.RAM_AW(9), .RAM_LAT(1)) u_lat1 (
    .i_clk(clk), .i_rst(rst), .i_start(st[0]), .i_sector(sec[0]),
    .i_ecc_calc(calc[0]), .i_ecc_stored(stor[0]),
    .o_ram_req(req[0]), .o_ram_addr(addr[0]), .o_ram_we(we[0]), .o_ram_wdata(wdata[0]),
    .i_ram_rdata(rd0), .o_busy(busy[0]), .o_done(done[0]), .o_status(status[0]), .o_err_loc(eloc[0]));

  nf_ecc_corrector #(.RAM_AW(9), .RAM_LAT(3)) u_lat3 (
    .i_clk(clk), .i_rst(rst), .i_start(st[1]), .i_sector(sec[1]),
    .i_ecc_calc(calc[1]), .i_ecc_stored(stor[1]),
    .o_ram_req(req[1]), .o_ram_addr(addr[1]), .o_ram_we(we[1]), .o_ram_wdata(wdata[1]),
    .i_ram_rdata(rd1), .o_busy(busy[1]), .o_done(done[1]), .o_status(status[1]), .o_err_loc(eloc[1]));

  // Page RAM models with a preload side door; write counts seen at the RAM itself.
  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];
  logic [1:0]  pl_en;
  logic [8:0]  pl_a;
  logic [31:0] pl_d;
  int wc0 = 0, wc1 = 0;

  always @(posedge clk) begin
    if (pl_en[0]) mem0[pl_a] <= pl_d;
    else if (we[0]) begin mem0[addr[0]] <= wdata[0]; wc0 <= wc0 + 1; end
    rd0 <= mem0[addr[0]];
  end
  always @(posedge clk) begin
    if (pl_en[1]) mem1[pl_a] <= pl_d;
    else if (we[1]) begin mem1[addr[1]] <= wdata[1]; wc1 <= wc1 + 1; end
    p1 <= mem1[addr[1]]; p2 <= p1; rd1 <= p2;
  end

  int checks = 0, failures = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [31:0] rmem(input int d, input logic [8:0] a);
    return d ? mem1[a] : mem0[a];
  endfunction

  // Reference: classification and target derived straight from the syndrome rules.
  function automatic void model(input logic [1:0] sc, input logic [23:0] syn,
                                output logic [1:0] est, output logic [11:0] el,
                                output logic [8:0] wa, output logic [31:0] mask);
    int b, bn;
    bit ok;
    est = 2'b00; el = '0; wa = '0; mask = '0; ok = 1'b1;
    if (syn == 24'h0) est = 2'b00;
    else if ($countones(syn) == 1) est = 2'b10;
    else begin
      for (int k = 0; k < 12; k++) begin
        if (syn[2*k] == syn[2*k+1]) ok = 1'b0;
        el[k] = syn[2*k+1];
      end
      if (ok) begin
        est  = 2'b01;
        b    = int'(el) / 8;
        bn   = int'(el) % 8;
        wa   = 9'(int'(sc) * 128 + b / 4);
        mask = 32'd1 << ((b % 4) * 8 + bn);
      end else begin
        est = 2'b11; el = '0;
      end
    end
  endfunction

  int r_dcyc, r_ndone, r_wcyc, r_nreq, r_addrbad, r_nwr;
  logic [1:0]  r_stat;
  logic [11:0] r_loc;
  logic [8:0]  r_waddr, r_a0;
  logic [31:0] r_wval;
  logic r_busy1, r_we5, r_busy5;

  // mode 0: plain; 1: second start during WAIT; 2: reset in the WR cycle (LAT=1 only)
  task automatic run(input int d, input int mode, input logic [1:0] sc, input logic [23:0] c,
                     input logic [23:0] s, input logic [8:0] pa, input logic [31:0] pd);
    int wbase;
    @(negedge clk); pl_en[d] = 1'b1; pl_a = pa; pl_d = pd;
    @(negedge clk); pl_en[d] = 1'b0;
    wbase = d ? wc1 : wc0;
    sec[d] = sc; calc[d] = c; stor[d] = s; st[d] = 1'b1;
    @(negedge clk); st[d] = 1'b0;
    calc[d] = 24'($urandom); stor[d] = 24'($urandom); sec[d] = 2'($urandom);
    r_dcyc = 0; r_ndone = 0; r_wcyc = 0; r_nreq = 0; r_addrbad = 0;
    r_stat = 'x; r_loc = 'x; r_waddr = '0; r_wval = '0; r_a0 = '0;
    r_busy1 = 1'b0; r_we5 = 1'bx; r_busy5 = 1'bx;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) r_busy1 = busy[d];
      if (done[d]) begin
        r_ndone++;
        if (r_dcyc == 0) begin r_dcyc = k; r_stat = status[d]; r_loc = eloc[d]; end
      end
      if (we[d]) begin r_wcyc = k; r_wval = wdata[d]; r_waddr = addr[d]; end
      if (req[d]) begin
        r_nreq++;
        if (r_nreq == 1) r_a0 = addr[d];
        else if (addr[d] != r_a0) r_addrbad++;
      end else if (addr[d] != 9'h0) r_addrbad++;
      if (mode == 1 && k == 3) begin st[d] = 1'b1; sec[d] = ~sc; calc[d] = c ^ 24'h5; stor[d] = s; end
      if (mode == 1 && k == 4) st[d] = 1'b0;
      if (mode == 2 && k == 4) rst = 1'b1;
      if (mode == 2 && k == 5) begin r_we5 = we[d]; r_busy5 = busy[d]; rst = 1'b0; end
      @(negedge clk);
    end
    r_nwr = (d ? wc1 : wc0) - wbase;
  endtask

  typedef struct {
    logic [1:0]  sc;
    logic [23:0] c, s;
    logic [8:0]  pa;
    logic [31:0] pd;
    logic [1:0]  est;
    logic [11:0] eloc;
    int          edcyc;
    int          enwr;
    logic [31:0] eword;
  } vec_t;
  vec_t tv[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  mst;
    logic [11:0] mloc;
    logic [8:0]  mwa, pa;
    logic [31:0] mmask, old;
    logic [23:0] c, syn;
    logic [11:0] l;
    logic [1:0]  sc;
    int kind;

    tv[0] = '{2'd0, 24'h3C5A96, 24'h3C5A96,            9'h010, 32'hCAFEF00D, 2'b00, 12'h000, 2, 0, 32'hCAFEF00D};
    tv[1] = '{2'd2, 24'h000000, 24'hA6599A,            9'h169, 32'h12345E78, 2'b01, 12'hD2B, 5, 1, 32'h12345678};
    tv[2] = '{2'd1, 24'h123456, 24'h123456 ^ 24'h000400, 9'h0AA, 32'h5555AAAA, 2'b10, 12'h000, 2, 0, 32'h5555AAAA};
    tv[3] = '{2'd3, 24'h000003, 24'h000000,            9'h1FF, 32'hFFFFFFFF, 2'b11, 12'h000, 2, 0, 32'hFFFFFFFF};
    tv[4] = '{2'd0, 24'h0000F0, 24'h000000,            9'h000, 32'h00000000, 2'b11, 12'h000, 2, 0, 32'h00000000};

    rst = 1'b1; st = '0; sec = '0; calc = '0; stor = '0; pl_en = '0; pl_a = '0; pl_d = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_outputs[%0d]", d),
          {busy[d], done[d], req[d], we[d], addr[d], wdata[d], status[d], eloc[d]}, 64'h0);
    // start coincident with reset must be dropped
    st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0; rst = 1'b0;
    chk("start_with_rst_busy", busy[0], 1'b0);

    for (int i = 0; i < 5; i++) begin
      run(0, 0, tv[i].sc, tv[i].c, tv[i].s, tv[i].pa, tv[i].pd);
      chk($sformatf("vec%0d_status", i), r_stat, tv[i].est);
      chk($sformatf("vec%0d_errloc", i), r_loc, tv[i].eloc);
      chk($sformatf("vec%0d_done_cycle", i), r_dcyc, tv[i].edcyc);
      chk($sformatf("vec%0d_done_count", i), r_ndone, 1);
      chk($sformatf("vec%0d_writes", i), r_nwr, tv[i].enwr);
      chk($sformatf("vec%0d_ram_word", i), rmem(0, tv[i].pa), tv[i].eword);
      chk($sformatf("vec%0d_req_cycles", i), r_nreq, tv[i].enwr ? 3 : 0);
      chk($sformatf("vec%0d_addr_stable", i), r_addrbad, 0);
      chk($sformatf("vec%0d_busy_c1", i), r_busy1, 1'b1);
      if (tv[i].enwr != 0) begin
        chk($sformatf("vec%0d_wr_cycle", i), r_wcyc, 4);
        chk($sformatf("vec%0d_wr_addr", i), r_waddr, tv[i].pa);
        chk($sformatf("vec%0d_wr_data", i), r_wval, tv[i].eword);
      end
    end

    for (int i = 0; i < 40; i++) begin
      kind = i % 4;
      sc = 2'($urandom);
      c  = 24'($urandom);
      l  = 12'($urandom_range(0, 4095));
      case (kind)
        0: syn = 24'h0;
        1: for (int k = 0; k < 12; k++) begin syn[2*k+1] = l[k]; syn[2*k] = ~l[k]; end
        2: syn = 24'h1 << $urandom_range(0, 23);
        default: syn = 24'($urandom);
      endcase
      model(sc, syn, mst, mloc, mwa, mmask);
      pa  = (mst == 2'b01) ? mwa : 9'($urandom);
      old = $urandom;
      run(0, 0, sc, c, c ^ syn, pa, old);
      chk($sformatf("rnd%0d_status", i), r_stat, mst);
      chk($sformatf("rnd%0d_errloc", i), r_loc, mloc);
      chk($sformatf("rnd%0d_done_cycle", i), r_dcyc, (mst == 2'b01) ? 5 : 2);
      chk($sformatf("rnd%0d_writes", i), r_nwr, (mst == 2'b01) ? 1 : 0);
      chk($sformatf("rnd%0d_ram_word", i), rmem(0, pa), old ^ mmask);
    end

    // second start during WAIT is ignored
    run(0, 1, tv[1].sc, tv[1].c, tv[1].s, tv[1].pa, tv[1].pd);
    chk("restart_status", r_stat, 2'b01);
    chk("restart_errloc", r_loc, 12'hD2B);
    chk("restart_done_cycle", r_dcyc, 5);
    chk("restart_done_count", r_ndone, 1);
    chk("restart_writes", r_nwr, 1);
    chk("restart_ram_word", rmem(0, 9'h169), 32'h12345678);

    // reset in the WR cycle: no write, no done, outputs idle
    run(0, 2, tv[1].sc, tv[1].c, tv[1].s, tv[1].pa, tv[1].pd);
    chk("rstwr_wr_seen_c4", r_wcyc, 4);
    chk("rstwr_done_count", r_ndone, 0);
    chk("rstwr_writes", r_nwr, 0);
    chk("rstwr_ram_word", rmem(0, 9'h169), 32'h12345E78);
    chk("rstwr_we_after", r_we5, 1'b0);
    chk("rstwr_busy_after", r_busy5, 1'b0);
    run(0, 0, tv[1].sc, tv[1].c, tv[1].s, tv[1].pa, tv[1].pd);
    chk("after_rst_status", r_stat, 2'b01);
    chk("after_rst_done_cycle", r_dcyc, 5);
    chk("after_rst_ram_word", rmem(0, 9'h169), 32'h12345678);

    // RAM_LAT = 3 correction
    run(1, 0, tv[1].sc, tv[1].c, tv[1].s, tv[1].pa, tv[1].pd);
    chk("lat3_status", r_stat, 2'b01);
    chk("lat3_errloc", r_loc, 12'hD2B);
    chk("lat3_done_cycle", r_dcyc, 7);
    chk("lat3_wr_cycle", r_wcyc, 6);
    chk("lat3_req_cycles", r_nreq, 5);
    chk("lat3_writes", r_nwr, 1);
    chk("lat3_ram_word", rmem(1, 9'h169), 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
